// File: rtl/ram_copy_engine.sv
// Block-copy initiator for a dual-port RAM: reads words on port A, writes them on port B one
// cycle later, one word per cycle, and returns the XOR checksum of the copied data.
module ram_copy_engine #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic          dir,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] checksum,
    output logic [AW-1:0] ram_addr_a,
    output logic          ram_wr_a,
    output logic [DW-1:0] ram_data_a,
    input  logic [DW-1:0] ram_q_a,
    output logic [AW-1:0] ram_addr_b,
    output logic          ram_wr_b,
    output logic [DW-1:0] ram_data_b
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StFin} state_e;

    localparam logic [AW:0] MaxLen = {1'b1, {AW{1'b0}}};

    state_e        state_q;
    logic [AW-1:0] dst_ptr_q;
    logic [AW:0]   len_q;
    logic [AW:0]   rd_cnt_q;
    logic          dir_q;

    function automatic logic [AW-1:0] step(input logic [AW-1:0] a, input logic down);
        return down ? a - AW'(1) : a + AW'(1);
    endfunction

    // Port A is read-only; port B write data is the registered read data passed straight through.
    assign ram_wr_a   = 1'b0;
    assign ram_data_a = '0;
    assign ram_data_b = ram_q_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            dst_ptr_q  <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            dir_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            checksum   <= '0;
            ram_addr_a <= '0;
            ram_addr_b <= '0;
            ram_wr_b   <= 1'b0;
        end else begin
            ram_wr_b <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (ram_wr_b) begin
                checksum <= checksum ^ ram_q_a;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len == '0 || len > MaxLen) begin
                            state_q <= StFin;
                            done    <= 1'b1;
                            err     <= (len > MaxLen);
                        end else begin
                            state_q    <= StRun;
                            busy       <= 1'b1;
                            ram_addr_a <= src;
                            dst_ptr_q  <= dst;
                            len_q      <= len;
                            dir_q      <= dir;
                            rd_cnt_q   <= (AW+1)'(1);
                            checksum   <= '0;
                        end
                    end
                end
                StRun: begin
                    // Write of the word read last cycle overlaps the next read.
                    ram_wr_b   <= 1'b1;
                    ram_addr_b <= dst_ptr_q;
                    dst_ptr_q  <= step(dst_ptr_q, dir_q);
                    if (rd_cnt_q == len_q) begin
                        state_q <= StFlush;
                    end else begin
                        ram_addr_a <= step(ram_addr_a, dir_q);
                        rd_cnt_q   <= rd_cnt_q + (AW+1)'(1);
                    end
                end
                StFlush: begin
                    state_q <= StFin;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
